// File: rtl/uart_msg_sequencer.sv
// Feeds a fixed message, byte by byte, into the uart_fsm transmitter in the baud_clk domain.
// Sends once per start pulse, or repeats with a programmable idle gap between messages.
module uart_msg_sequencer #(
    parameter int                              DATA_WIDTH  = 8,
    parameter int                              MSG_LEN     = 15,
    parameter logic [DATA_WIDTH*MSG_LEN-1:0]   MSG         = "Hello, World!\r\n",
    parameter int                              GAP_CYCLES  = 9600,
    parameter bit                              AUTO_REPEAT = 1'b1,
    parameter int                              ACK_TIMEOUT = 16,
    localparam int                             IDX_W       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  ready,
    output logic                  tx_en,
    output logic                  load,
    output logic [DATA_WIDTH-1:0] load_byte,
    output logic [IDX_W-1:0]      byte_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            state_dbg
);

    // Handshake: load is a one-cycle valid with load_byte; uart_fsm accepts by dropping
    // ready, and a byte is only offered after ready has been seen high.
    localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_RDY  = 3'd1,
        S_LOAD      = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_LAST = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    state_t                state, state_next;
    logic                  repeat_armed, armed_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  tx_en_next, load_next, busy_next, done_next, err_next;
    logic [DATA_WIDTH-1:0] load_byte_next;
    logic [IDX_W-1:0]      byte_idx_next;
    logic                  last_byte, ack_expired, gap_expired;

    function automatic logic [DATA_WIDTH-1:0] msg_at(input logic [IDX_W-1:0] idx);
        return MSG[(MSG_LEN - 1 - int'(idx)) * DATA_WIDTH +: DATA_WIDTH];
    endfunction

    assign last_byte   = (byte_idx == IDX_W'(MSG_LEN - 1));
    assign ack_expired = (cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign gap_expired = (cnt == CNT_W'(GAP_CYCLES - 1));
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            repeat_armed <= AUTO_REPEAT;
            cnt          <= '0;
            tx_en        <= 1'b0;
            load         <= 1'b0;
            load_byte    <= '0;
            byte_idx     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_next;
            repeat_armed <= armed_next;
            cnt          <= cnt_next;
            tx_en        <= tx_en_next;
            load         <= load_next;
            load_byte    <= load_byte_next;
            byte_idx     <= byte_idx_next;
            busy         <= busy_next;
            done         <= done_next;
            err          <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (start || repeat_armed) state_next = S_WAIT_RDY;
            S_WAIT_RDY:  if (ready) state_next = S_LOAD;
            S_LOAD:      state_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!ready)           state_next = last_byte ? S_WAIT_LAST : S_WAIT_RDY;
                else if (ack_expired) state_next = S_IDLE;
            end
            S_WAIT_LAST: begin
                if (ready) begin
                    if (!repeat_armed)       state_next = S_IDLE;
                    else if (GAP_CYCLES > 0) state_next = S_GAP;
                    else                     state_next = S_WAIT_RDY;
                end
            end
            S_GAP:       if (gap_expired) state_next = S_WAIT_RDY;
            default:     state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    always_comb begin
        armed_next     = repeat_armed;
        cnt_next       = cnt;
        tx_en_next     = tx_en;
        load_next      = 1'b0;
        load_byte_next = load_byte;
        byte_idx_next  = byte_idx;
        busy_next      = busy;
        done_next      = 1'b0;
        err_next       = err;
        case (state)
            S_IDLE: begin
                if (abort) begin
                    armed_next = 1'b0;
                end else if (start || repeat_armed) begin
                    byte_idx_next = '0;
                    tx_en_next    = 1'b1;
                    busy_next     = 1'b1;
                    if (start) begin
                        armed_next = AUTO_REPEAT;
                        err_next   = 1'b0;
                    end
                end
            end
            S_WAIT_RDY: if (ready) load_byte_next = msg_at(byte_idx);
            S_LOAD: begin
                load_next = 1'b1;
                cnt_next  = '0;
            end
            S_WAIT_ACK: begin
                cnt_next = cnt + CNT_W'(1);
                if (!ready) begin
                    if (!last_byte) byte_idx_next = byte_idx + IDX_W'(1);
                end else if (ack_expired) begin
                    err_next   = 1'b1;
                    tx_en_next = 1'b0;
                    busy_next  = 1'b0;
                    armed_next = 1'b0;
                end
            end
            S_WAIT_LAST: begin
                if (ready) begin
                    done_next  = 1'b1;
                    tx_en_next = 1'b0;
                    cnt_next   = '0;
                    if (!repeat_armed) begin
                        busy_next = 1'b0;
                    end else if (GAP_CYCLES == 0) begin
                        byte_idx_next = '0;
                        tx_en_next    = 1'b1;
                    end
                end
            end
            S_GAP: begin
                cnt_next = cnt + CNT_W'(1);
                if (gap_expired) begin
                    byte_idx_next = '0;
                    tx_en_next    = 1'b1;
                end
            end
            default: ;
        endcase
        // Abort outside IDLE drops everything; a byte already in uart_fsm finishes by itself.
        if (abort && state != S_IDLE) begin
            load_next     = 1'b0;
            tx_en_next    = 1'b0;
            busy_next     = 1'b0;
            done_next     = 1'b0;
            err_next      = err;
            byte_idx_next = '0;
            armed_next    = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Directed bench for uart_msg_sequencer: three instances (default, one-shot, single-byte back-to-back),
// each driven by a simple uart model that drops ready 1 cycle after load and raises it 10 cycles later.
module tb_uart_msg_sequencer;

  typedef struct {
    int         idx;
    logic [7:0] exp_byte;
  } msg_vec_t;

  typedef struct {
    bit         start;
    bit         abort;
    bit         exp_busy;
    bit         exp_tx_en;
    logic [2:0] exp_state;
  } step_t;

  logic       clk = 1'b0;
  logic       rst [3];
  logic       start [3];
  logic       abort [3];
  logic       ready [3];
  logic       tx_en [3];
  logic       load [3];
  logic [7:0] load_byte [3];
  logic [3:0] byte_idx [3];
  logic       busy [3];
  logic       done [3];
  logic       err [3];
  logic [2:0] state_dbg [3];
  logic       idx_c;

  int         mode [3];
  int         ucnt [3];
  int         cycle = 0;
  int         prev_load_cycle = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  logic [7:0] exp_q [$];
  int         exp_idx_q [$];
  msg_vec_t   msg_tab [15];
  step_t      steps [9];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  uart_msg_sequencer dut_a (
    .clk(clk), .rst(rst[0]), .start(start[0]), .abort(abort[0]), .ready(ready[0]),
    .tx_en(tx_en[0]), .load(load[0]), .load_byte(load_byte[0]), .byte_idx(byte_idx[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .state_dbg(state_dbg[0])
  );

  uart_msg_sequencer #(.AUTO_REPEAT(1'b0), .GAP_CYCLES(20)) dut_b (
    .clk(clk), .rst(rst[1]), .start(start[1]), .abort(abort[1]), .ready(ready[1]),
    .tx_en(tx_en[1]), .load(load[1]), .load_byte(load_byte[1]), .byte_idx(byte_idx[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .state_dbg(state_dbg[1])
  );

  uart_msg_sequencer #(.MSG_LEN(1), .MSG(8'h55), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .rst(rst[2]), .start(start[2]), .abort(abort[2]), .ready(ready[2]),
    .tx_en(tx_en[2]), .load(load[2]), .load_byte(load_byte[2]), .byte_idx(idx_c),
    .busy(busy[2]), .done(done[2]), .err(err[2]), .state_dbg(state_dbg[2])
  );

  assign byte_idx[2] = {3'b000, idx_c};

  // uart model; mode 1 holds ready high, mode 2 holds it low
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k])              ucnt[k] <= 0;
      else if (load[k])        ucnt[k] <= 10;
      else if (ucnt[k] != 0)   ucnt[k] <= ucnt[k] - 1;
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ready[k] = (mode[k] == 1) ? 1'b1 : (mode[k] == 2) ? 1'b0 : (ucnt[k] == 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    tick(1);
    start[k] = 1'b0;
  endtask

  task automatic pulse_abort(input int k);
    abort[k] = 1'b1;
    tick(1);
    abort[k] = 1'b0;
  endtask

  task automatic load_msg();
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(msg_tab[i].exp_byte);
      exp_idx_q.push_back(msg_tab[i].idx);
    end
  endtask

  // Scoreboard over load pulses; returns at done (or after stop_after loads when > 0).
  task automatic expect_message(input int k, input int budget, input int first_rel,
                                input int first_from_prev, input int stop_after, input string tag);
    int cyc = 0;
    int seen = 0;
    int last_c = 0;
    bit got_done = 1'b0;
    while (!got_done && cyc < budget && !(stop_after > 0 && seen == stop_after)) begin
      @(negedge clk);
      cyc++;
      if (load[k]) begin
        if (seen == 0) begin
          if (first_rel >= 0)       check({tag, " first load latency"}, cyc, first_rel);
          if (first_from_prev >= 0) check({tag, " load-to-load across done"}, cycle - prev_load_cycle, first_from_prev);
        end else begin
          check({tag, " load spacing"}, cycle - last_c, 13);
        end
        if (exp_q.size() > 0) begin
          check($sformatf("%s byte%0d", tag, seen), load_byte[k], exp_q.pop_front());
          check($sformatf("%s idx%0d", tag, seen), byte_idx[k], exp_idx_q.pop_front());
        end else begin
          check({tag, " unexpected extra load"}, exp_q.size(), 1);
        end
        check({tag, " tx_en during load"}, tx_en[k], 1);
        last_c = cycle;
        prev_load_cycle = cycle;
        seen++;
      end
      if (done[k]) begin
        got_done = 1'b1;
        check({tag, " done early"}, seen, 15 - exp_q.size() + (exp_q.size() == 0 ? seen - 15 : 0));
        check({tag, " done latency"}, cycle - last_c, 12);
      end
    end
    if (stop_after > 0) begin
      check({tag, " loads before stop"}, seen, stop_after);
      exp_q.delete();
      exp_idx_q.delete();
    end else begin
      check({tag, " done seen"}, got_done, 1);
      check({tag, " bytes left"}, exp_q.size(), 0);
    end
  endtask

  initial begin
    int n;
    int loads;
    int dones;
    int lows;
    logic [7:0] hello [15];
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57,
              8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};
    for (int i = 0; i < 15; i++) msg_tab[i] = '{i, hello[i]};
    // {start, abort} -> {busy, tx_en, state}, applied with ready held low
    steps[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1};
    steps[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
    steps[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1};
    steps[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
    steps[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1};
    steps[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    steps[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    steps[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    steps[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; abort[k] = 1'b0; mode[k] = 0;
    end
    tick(3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d tx_en", k), tx_en[k], 0);
      check($sformatf("reset%0d load", k), load[k], 0);
      check($sformatf("reset%0d busy", k), busy[k], 0);
      check($sformatf("reset%0d done", k), done[k], 0);
      check($sformatf("reset%0d err", k), err[k], 0);
      check($sformatf("reset%0d load_byte", k), load_byte[k], 0);
      check($sformatf("reset%0d byte_idx", k), byte_idx[k], 0);
    end

    // Auto-repeat out of reset, gap length, then repeat
    rst[0] = 1'b0;
    load_msg();
    expect_message(0, 400, 3, -1, 0, "t1 msg");
    check("t1 tx_en at done", tx_en[0], 0);
    check("t1 busy at done", busy[0], 1);
    n = 0; lows = 0;
    while (!tx_en[0] && n < 10000) begin
      n++;
      if (!busy[0]) lows++;
      @(negedge clk);
    end
    check("t1 gap length", n, 9600);
    check("t1 busy low in gap", lows, 0);
    load_msg();
    expect_message(0, 200, 2, -1, 5, "t1 repeat");

    // Abort mid-message, then restart
    n = 0;
    while (byte_idx[0] != 4'd5 && n < 30) begin tick(1); n++; end
    check("t3 reached idx5", byte_idx[0], 5);
    pulse_abort(0);
    check("t3 load after abort", load[0], 0);
    check("t3 tx_en after abort", tx_en[0], 0);
    check("t3 busy after abort", busy[0], 0);
    check("t3 byte_idx after abort", byte_idx[0], 0);
    loads = 0; dones = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (load[0]) loads++;
      if (done[0] || busy[0]) dones++;
    end
    check("t3 loads after abort", loads, 0);
    check("t3 done/busy after abort", dones, 0);
    pulse_start(0);
    load_msg();
    expect_message(0, 400, 2, -1, 0, "t3 restart");

    // Ack timeout with ready stuck high
    pulse_abort(0);
    check("t4 busy after abort", busy[0], 0);
    mode[0] = 1;
    pulse_start(0);
    n = 0;
    while (!load[0] && n < 10) begin tick(1); n++; end
    check("t4 load seen", load[0], 1);
    tick(15);
    check("t4 err before timeout", err[0], 0);
    check("t4 busy before timeout", busy[0], 1);
    tick(1);
    check("t4 err at timeout", err[0], 1);
    check("t4 busy at timeout", busy[0], 0);
    check("t4 tx_en at timeout", tx_en[0], 0);
    loads = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (load[0] || done[0]) loads++;
    end
    check("t4 activity after timeout", loads, 0);
    check("t4 err sticky", err[0], 1);
    mode[0] = 0;
    pulse_start(0);
    check("t4 err cleared by start", err[0], 0);
    check("t4 busy after start", busy[0], 1);
    load_msg();
    expect_message(0, 400, 2, -1, 0, "t4 restart");

    // ready held low, start during busy, abort+start together
    pulse_abort(0);
    mode[0] = 2;
    for (int i = 0; i < 9; i++) begin
      start[0] = steps[i].start;
      abort[0] = steps[i].abort;
      tick(1);
      check($sformatf("t5 step%0d busy", i), busy[0], steps[i].exp_busy);
      check($sformatf("t5 step%0d tx_en", i), tx_en[0], steps[i].exp_tx_en);
      check($sformatf("t5 step%0d load", i), load[0], 0);
      check($sformatf("t5 step%0d state", i), state_dbg[0], steps[i].exp_state);
      check($sformatf("t5 step%0d byte_idx", i), byte_idx[0], 0);
    end
    start[0] = 1'b0;
    abort[0] = 1'b0;
    mode[0] = 0;

    // One-shot instance: idle until start, single message per start
    rst[1] = 1'b0;
    loads = 0; lows = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (load[1]) loads++;
      if (busy[1]) lows++;
    end
    check("t2 loads before start", loads, 0);
    check("t2 busy before start", lows, 0);
    pulse_start(1);
    load_msg();
    expect_message(1, 400, 2, -1, 0, "t2 msg");
    check("t2 busy at done", busy[1], 0);
    check("t2 tx_en at done", tx_en[1], 0);
    start[1] = 1'b1;
    tick(2);
    start[1] = 1'b0;
    load_msg();
    expect_message(1, 400, 1, -1, 0, "t2 msg with busy start");
    loads = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (load[1] || busy[1]) loads++;
    end
    check("t2 idle after message", loads, 0);

    // Single-byte message, no gap
    rst[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h55);
      exp_idx_q.push_back(0);
      expect_message(2, 100, (i == 0) ? 3 : -1, (i == 0) ? -1 : 14, 0, $sformatf("t6 rep%0d", i));
      check($sformatf("t6 rep%0d tx_en at done", i), tx_en[2], 1);
      check($sformatf("t6 rep%0d busy at done", i), busy[2], 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
